// File: rtl/inst_sram_resp.sv
// inst_sram_resp: single-port instruction SRAM responder.
// One-cycle registered read, byte-lane writes with write-first read data,
// out-of-window accesses answered with zero data and a one-cycle error pulse.
// Optional power-up clear of the whole array behind macro INST_SRAM_CLEAR_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | zeroing one word per cycle from index 0, requests not accepted
// ST_IDLE  | serving requests, held until reset
module inst_sram_resp #(
  parameter logic [31:0] ADDR_BASE  = 32'h1fc0_0000,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        sram_ready,
  output logic        sram_err,
  output logic [31:0] rd_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

`ifdef INST_SRAM_CLEAR_EN
  localparam state_t RST_STATE = ST_CLEAR;
`else
  localparam state_t RST_STATE = ST_IDLE;
`endif

  state_t                  state_q, state_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [31:0]             rd_cnt_q, rd_cnt_d;

  logic [31:0]             mem_q [DEPTH];
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_widx;
  logic [31:0]             mem_wdata;

  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    req_in_win;
  logic                    req_accept;
  logic                    req_is_wr;
  logic [31:0]             cur_word;
  logic [31:0]             merged_word;

  // Byte offset within a word carries no meaning for a word-wide array.
  logic                    unused_addr_lsb;
  assign unused_addr_lsb = ^inst_sram_addr[1:0];

`ifdef INST_SRAM_CLEAR_EN
  logic [DEPTH_LOG2-1:0]   clr_ptr_q, clr_ptr_d;
  assign sram_ready = (state_q == ST_IDLE);
`else
  assign sram_ready = 1'b1;
`endif

  assign req_idx    = inst_sram_addr[DEPTH_LOG2+1:2];
  assign req_in_win = (inst_sram_addr[31:DEPTH_LOG2+2] == ADDR_BASE[31:DEPTH_LOG2+2]);
  assign req_accept = inst_sram_en & sram_ready;
  assign req_is_wr  = |inst_sram_wen;
  assign cur_word   = mem_q[req_idx];

  // Merge enabled write lanes over the currently stored word.
  always_comb begin
    merged_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (inst_sram_wen[i]) begin
        merged_word[8*i +: 8] = inst_sram_wdata[8*i +: 8];
      end
    end
  end

  // Next-state, memory write port and response computation.
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    rd_cnt_d  = rd_cnt_q;
    mem_we    = 1'b0;
    mem_widx  = req_idx;
    mem_wdata = merged_word;
`ifdef INST_SRAM_CLEAR_EN
    clr_ptr_d = clr_ptr_q;
`endif
    case (state_q)
      ST_CLEAR: begin
`ifdef INST_SRAM_CLEAR_EN
        mem_we    = 1'b1;
        mem_widx  = clr_ptr_q;
        mem_wdata = 32'h0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == {DEPTH_LOG2{1'b1}}) begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        if (req_accept) begin
          if (req_in_win) begin
            if (req_is_wr) begin
              mem_we  = 1'b1;
              rdata_d = merged_word;
            end else begin
              rdata_d  = cur_word;
              rd_cnt_d = rd_cnt_q + 32'd1;
            end
          end else begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  // Control and response registers, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RST_STATE;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rd_cnt_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

`ifdef INST_SRAM_CLEAR_EN
  // Clear pointer restarts from index 0 on every reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_ptr_q <= '0;
    end else begin
      clr_ptr_q <= clr_ptr_d;
    end
  end
`endif

  // Storage array; contents survive reset, writes are blocked while it is held.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  assign inst_sram_rdata = rdata_q;
  assign sram_err        = err_q;
  assign rd_cnt          = rd_cnt_q;

endmodule

// File: tb/tb_inst_sram_resp.sv
// Scoreboard bench for inst_sram_resp with DEPTH_LOG2=4.
module tb_inst_sram_resp;

  logic        clk;
  logic        reset;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        sram_ready;
  logic        sram_err;
  logic [31:0] rd_cnt;

  inst_sram_resp #(.ADDR_BASE(32'h1fc0_0000), .DEPTH_LOG2(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .sram_ready      (sram_ready),
    .sram_err        (sram_err),
    .rd_cnt          (rd_cnt)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt = 32'h0;
  bit          pend = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: responses appear the cycle after an accepted request.
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rdata", inst_sram_rdata, e.rdata);
        chk("err", {31'h0, sram_err}, {31'h0, e.err});
        chk("rd_cnt", rd_cnt, e.cnt);
      end
    end
    pend = inst_sram_en && sram_ready && !reset;
  end

  task automatic req(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    @(posedge clk);
    #1;
    inst_sram_en    = 1'b1;
    inst_sram_wen   = wen;
    inst_sram_addr  = addr;
    inst_sram_wdata = wdata;
    if (!exp_err && wen == 4'h0) exp_cnt = exp_cnt + 32'd1;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cnt   = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      inst_sram_en = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input logic exp_ready);
    chk("rst_rdata", inst_sram_rdata, 32'h0);
    chk("rst_err", {31'h0, sram_err}, 32'h0);
    chk("rst_rd_cnt", rd_cnt, 32'h0);
    chk("rst_ready", {31'h0, sram_ready}, {31'h0, exp_ready});
  endtask

  // Release reset and check the ready profile that follows.
  task automatic release_and_wait_ready();
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_cnt = 32'h0;
`ifdef INST_SRAM_CLEAR_EN
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("clear_ready_low", {31'h0, sram_ready}, 32'h0);
    end
    @(negedge clk);
    chk("clear_ready_high", {31'h0, sram_ready}, 32'h1);
`else
    @(negedge clk);
    chk("ready_const", {31'h0, sram_ready}, 32'h1);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    inst_sram_en    = 1'b0;
    inst_sram_wen   = 4'h0;
    inst_sram_addr  = 32'h0;
    inst_sram_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
`ifdef INST_SRAM_CLEAR_EN
    check_reset_outputs(1'b0);
`else
    check_reset_outputs(1'b1);
`endif
    release_and_wait_ready();

`ifndef INST_SRAM_CLEAR_EN
    req(4'hf, 32'h1fc0_0008, 32'h0000_0000, 32'h0000_0000, 1'b0);
`endif
    req(4'h0, 32'h1fc0_0008, 32'h0,         32'h0000_0000, 1'b0);
    // write then read same word, back to back
    req(4'hf, 32'h1fc0_0000, 32'h2408_0001, 32'h2408_0001, 1'b0);
    req(4'h0, 32'h1fc0_0000, 32'h0,         32'h2408_0001, 1'b0);
    // single-lane write, low address bits ignored
    req(4'hf, 32'h1fc0_0004, 32'h1122_3344, 32'h1122_3344, 1'b0);
    req(4'h2, 32'h1fc0_0006, 32'h0000_aa00, 32'h1122_aa44, 1'b0);
    req(4'h0, 32'h1fc0_0007, 32'h0,         32'h1122_aa44, 1'b0);
    // out-of-window read and write (0x40 aliases index 0 but is outside)
    req(4'h0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b1);
    req(4'hf, 32'h1fc0_0040, 32'hdead_beef, 32'h0000_0000, 1'b1);
    req(4'h0, 32'h1fc0_0000, 32'h0,         32'h2408_0001, 1'b0);
    // two-lane write
    req(4'h9, 32'h1fc0_0004, 32'ha1b2_c3d4, 32'ha122_aad4, 1'b0);
    req(4'h0, 32'h1fc0_0004, 32'h0,         32'ha122_aad4, 1'b0);

    // hold: no accepted request keeps rdata and clears err
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      inst_sram_en = 1'b0;
      @(negedge clk);
      chk("hold_rdata", inst_sram_rdata, 32'ha122_aad4);
      chk("hold_err", {31'h0, sram_err}, 32'h0);
    end

    // read counter wrap
    force dut.rd_cnt_q = 32'hffff_ffff;
    #1;
    release dut.rd_cnt_q;
    exp_cnt = 32'hffff_ffff;
    req(4'h0, 32'h1fc0_0000, 32'h0, 32'h2408_0001, 1'b0);
    req(4'h0, 32'h1fc0_0004, 32'h0, 32'ha122_aad4, 1'b0);
    idle(2);

    reset = 1'b1;
    #1;
`ifdef INST_SRAM_CLEAR_EN
    check_reset_outputs(1'b0);
    release_and_wait_ready();
    idle(1);
    // abandon clear at pointer 5
    reset = 1'b1;
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs(1'b0);
    release_and_wait_ready();
    req(4'h0, 32'h1fc0_0000, 32'h0, 32'h0000_0000, 1'b0);
    req(4'h0, 32'h1fc0_0004, 32'h0, 32'h0000_0000, 1'b0);
    req(4'h0, 32'h1fc0_003c, 32'h0, 32'h0000_0000, 1'b0);
`else
    check_reset_outputs(1'b1);
    release_and_wait_ready();
    // memory is not reset directly
    req(4'h0, 32'h1fc0_0000, 32'h0, 32'h2408_0001, 1'b0);
    req(4'h0, 32'h1fc0_0004, 32'h0, 32'ha122_aad4, 1'b0);
`endif
    idle(3);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
